// File: rtl/cdf_compute_stage.sv
// cdf_compute_stage: histogram to cumulative distribution, one 8-bin word per RD/CALC/WR pass (macro CDF_SATURATE_EN: saturating adds)
module cdf_compute_stage #(
   parameter logic [15:0] HIST_BASE_ADDR = 16'd0,
   parameter logic [15:0] CDF_BASE_ADDR = 16'd32,
   parameter int NUM_WORDS = 32,
   parameter int BIN_WIDTH = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic start_cdf,
   output logic [15:0] hist_mem_raddr,
   input  logic [8*BIN_WIDTH-1:0] hist_mem_rdata,
   output logic cdf_mem_WE,
   output logic [15:0] cdf_mem_waddr,
   output logic [8*BIN_WIDTH-1:0] cdf_mem_wdata,
   output logic [BIN_WIDTH-1:0] cdf_min,
   output logic [BIN_WIDTH-1:0] cdf_total,
   output logic cdf_busy,
   output logic cdf_computation_done
);
   localparam int KW = $clog2(NUM_WORDS);
   typedef enum logic [2:0] {IDLE, RD, CALC, WR, DONE} state_t;
   state_t state, next;
   logic [KW-1:0] k;
   logic [BIN_WIDTH-1:0] carry, acc, min_val;
   logic [7:0][BIN_WIDTH-1:0] s;
   logic [15:0] raddr_q, rd_addr;
   logic min_found, min_hit, last;
`ifdef CDF_SATURATE_EN
   logic [BIN_WIDTH:0] wide;
`endif
   assign rd_addr = HIST_BASE_ADDR + 16'(k);
   assign last = k == KW'(NUM_WORDS - 1);
   // prefix-sum chain across the 8 lanes, seeded by the carry from earlier words
   always_comb begin
      acc = carry;
      s = '0;
      for (int i = 0; i < 8; i++) begin
`ifdef CDF_SATURATE_EN
         wide = {1'b0, acc} + {1'b0, hist_mem_rdata[BIN_WIDTH*i +: BIN_WIDTH]};
         acc = wide[BIN_WIDTH] ? {BIN_WIDTH{1'b1}} : wide[BIN_WIDTH-1:0];
`else
         acc = acc + hist_mem_rdata[BIN_WIDTH*i +: BIN_WIDTH];
`endif
         s[i] = acc;
      end
   end
   // lowest lane holding a non-zero cumulative value
   always_comb begin
      min_val = '0;
      min_hit = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         if (s[i] != '0) begin
            min_val = s[i];
            min_hit = 1'b1;
         end
      end
   end
   // state register
   always_ff @(posedge clock) begin
      if (!reset) state <= IDLE;
      else state <= next;
   end
   // next state and state-decoded outputs
   always_comb begin
      next = state == IDLE ? (start_cdf ? RD : IDLE) :
             state == RD   ? CALC :
             state == CALC ? WR :
             state == WR   ? (last ? DONE : RD) : IDLE;
      cdf_mem_WE = state == WR;
      cdf_mem_waddr = cdf_mem_WE ? CDF_BASE_ADDR + 16'(k) : '0;
      cdf_busy = state inside {RD, CALC, WR};
      cdf_computation_done = state == DONE;
      hist_mem_raddr = state == RD ? rd_addr : raddr_q;
   end
   // datapath registers: word counter, carry, CDF word and summary values
   always_ff @(posedge clock) begin
      if (!reset) begin
         k <= '0;
         carry <= '0;
         min_found <= 1'b0;
         cdf_min <= '0;
         cdf_total <= '0;
         cdf_mem_wdata <= '0;
         raddr_q <= '0;
      end else begin
         if (state == IDLE && start_cdf) begin
            k <= '0;
            carry <= '0;
            min_found <= 1'b0;
            cdf_min <= '0;
            cdf_total <= '0;
         end
         if (state == RD) raddr_q <= rd_addr;
         if (state == CALC) begin
            cdf_mem_wdata <= s;
            carry <= s[7];
            if (!min_found && min_hit) begin
               cdf_min <= min_val;
               min_found <= 1'b1;
            end
         end
         if (state == WR) begin
            if (last) cdf_total <= carry;
            else k <= k + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_cdf_compute_stage.sv
// tb_cdf_compute_stage: scoreboard bench for cdf_compute_stage with directed histograms
module tb_cdf_compute_stage;
   logic clock = 1'b0, reset = 1'b0, start_cdf = 1'b0;
   logic [15:0] hist_mem_raddr, cdf_mem_waddr, cdf_min, cdf_total;
   logic [127:0] hist_mem_rdata = '0, cdf_mem_wdata;
   logic cdf_mem_WE, cdf_busy, cdf_computation_done;

   cdf_compute_stage dut (
      .clock(clock), .reset(reset), .start_cdf(start_cdf),
      .hist_mem_raddr(hist_mem_raddr), .hist_mem_rdata(hist_mem_rdata),
      .cdf_mem_WE(cdf_mem_WE), .cdf_mem_waddr(cdf_mem_waddr), .cdf_mem_wdata(cdf_mem_wdata),
      .cdf_min(cdf_min), .cdf_total(cdf_total),
      .cdf_busy(cdf_busy), .cdf_computation_done(cdf_computation_done)
   );

   typedef struct {int cyc; logic [15:0] addr; logic [127:0] data;} wr_t;
   wr_t exp_q[$];
   int done_q[$];
   logic [127:0] hist[64];
   logic [127:0] seen[32];
   int n_checks = 0, n_fail = 0, cyc = 0, t0 = 0;
   bit run_active = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   always @(posedge clock) hist_mem_rdata <= hist[hist_mem_raddr[5:0]];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor: pops expected writes and done pulses as the DUT presents them
   always @(negedge clock) begin
      int rel;
      wr_t e;
      rel = cyc - t0;
      if (run_active) check("busy", cdf_busy, 128'(rel >= 1 && rel <= 96));
      if (cdf_mem_WE === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %0d expected no write", cdf_mem_waddr);
         end else begin
            e = exp_q.pop_front();
            check("wr_cycle", 128'(rel), 128'(e.cyc));
            check("wr_addr", cdf_mem_waddr, e.addr);
            check("wr_data", cdf_mem_wdata, e.data);
            seen[cdf_mem_waddr[4:0]] = cdf_mem_wdata;
         end
      end
      if (cdf_computation_done === 1'b1) begin
         if (done_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got pulse at cycle %0d expected none", rel);
         end else check("done_cycle", 128'(rel), 128'(done_q.pop_front()));
      end
   end

   task automatic fill(input int mode);
      for (int k = 0; k < 32; k++)
         for (int i = 0; i < 8; i++)
            hist[k][16*i +: 16] = mode == 0 ? 16'd0 : mode == 1 ? 16'd1 :
                                  mode == 2 ? ((8*k + i) == 100 ? 16'd4096 : 16'd0) : 16'd300;
   endtask

   task automatic build_expect();
      int unsigned acc;
      logic [127:0] w;
      acc = 0;
      for (int k = 0; k < 32; k++) begin
         w = '0;
         for (int i = 0; i < 8; i++) begin
            acc = acc + 32'(hist[k][16*i +: 16]);
`ifdef CDF_SATURATE_EN
            if (acc > 65535) acc = 65535;
`else
            acc = acc % 65536;
`endif
            w[16*i +: 16] = acc[15:0];
         end
         exp_q.push_back('{3*k + 3, 16'(32 + k), w});
      end
      done_q.push_back(97);
   endtask

   task automatic start_run();
      build_expect();
      @(posedge clock); #1 start_cdf = 1'b1;
      @(posedge clock);
      t0 = cyc;
      run_active = 1;
      #1 start_cdf = 1'b0;
   endtask

   task automatic run(input bit restart, input logic [15:0] emin, input logic [15:0] etot);
      bit got;
      start_run();
      got = 0;
      for (int i = 1; i <= 150 && !got; i++) begin
         if (cdf_computation_done) got = 1;
         else begin
            if (restart && i == 39) start_cdf = 1'b1;
            if (i == 40) start_cdf = 1'b0;
            @(posedge clock); #1;
         end
      end
      check("done_seen", 128'(got), 128'(1));
      if (!got) $display("FAIL done_timeout: got no done within 150 cycles expected one");
      start_cdf = 1'b1;
      @(posedge clock); #1 start_cdf = 1'b0;
      check("start_in_done_ignored", cdf_busy, 0);
      check("writes_drained", 128'(exp_q.size()), 0);
      check("done_drained", 128'(done_q.size()), 0);
      check("cdf_min", cdf_min, emin);
      check("cdf_total", cdf_total, etot);
      @(posedge clock); #1;
      check("idle_after_done", cdf_busy, 0);
      run_active = 0;
   endtask

   initial begin
      for (int k = 0; k < 64; k++) hist[k] = '0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_we", cdf_mem_WE, 0);
      check("rst_busy", cdf_busy, 0);
      check("rst_done", cdf_computation_done, 0);
      check("rst_min", cdf_min, 0);
      check("rst_total", cdf_total, 0);
      check("rst_wdata", cdf_mem_wdata, 0);
      check("rst_raddr", hist_mem_raddr, 0);
      check("rst_waddr", cdf_mem_waddr, 0);
      reset = 1'b1;
      fill(0);
      run(0, 16'd0, 16'd0);
      check("zero_w31", seen[31], 0);
      fill(1);
      run(0, 16'd1, 16'd256);
      check("ones_w0", seen[0], 128'h0008_0007_0006_0005_0004_0003_0002_0001);
      check("ones_w31_l7", seen[31][127:112], 16'd256);
      fill(2);
      run(0, 16'd4096, 16'd4096);
      check("spike_w11", seen[11], 0);
      check("spike_w12", seen[12], 128'h1000_1000_1000_1000_0000_0000_0000_0000);
      check("spike_w13_l0", seen[13][15:0], 16'd4096);
      fill(3);
`ifdef CDF_SATURATE_EN
      run(0, 16'd300, 16'hFFFF);
      check("b300_w27_l2", seen[27][47:32], 16'hFFFF);
`else
      run(0, 16'd300, 16'd11264);
      check("b300_w27_l2", seen[27][47:32], 16'd164);
`endif
      check("b300_w27_l1", seen[27][31:16], 16'd65400);
      fill(1);
      run(1, 16'd1, 16'd256);
      run(0, 16'd1, 16'd256);
      start_run();
      repeat (48) @(posedge clock);
      #1;
      check("pre_reset_min", cdf_min, 16'd1);
      reset = 1'b0;
      exp_q.delete();
      done_q.delete();
      run_active = 0;
      @(posedge clock); #1;
      check("abort_we", cdf_mem_WE, 0);
      check("abort_busy", cdf_busy, 0);
      check("abort_min", cdf_min, 0);
      check("abort_total", cdf_total, 0);
      check("abort_wdata", cdf_mem_wdata, 0);
      check("abort_raddr", hist_mem_raddr, 0);
      reset = 1'b1;
      repeat (60) @(posedge clock);
      #1;
      check("abort_still_idle", cdf_busy, 0);
      run(0, 16'd1, 16'd256);
      check("post_reset_w31_l7", seen[31][127:112], 16'd256);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
